output_port_uart: RTL and testbench
===================================

# output_port_uart

Serial output port on the CPU's memory bus. It snoops RAM writes, captures every byte stored to the output address into a small FIFO, and shifts each byte out as an 8N1 UART frame on TXD. It replaces the single-flip-flop SERIAL_OUT path with a framed, buffered stream that a PC terminal or logic analyser can decode. It sits beside the RAM and shares its WE, address and data-out connections.

## Interface

Parameters:
- PORT_ADDR, 8'hFF, RAM address treated as the output port
- CLKS_PER_BIT, 10, CLK cycles per UART bit; legal range 2..65535
- FIFO_DEPTH, 4, byte entries; must be a power of two, 2..16

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  system clock; all state changes on its rising edge
- CLR  in  1  asynchronous active-high reset
- WE  in  1  RAM write enable
- ADDR  in  8  RAM address (output of the address mux)
- DIN  in  8  low byte of the RAM write data (accumulator value)
- TXD  out  1  UART serial line; idles high
- BUSY  out  1  high while a frame is being transmitted
- EMPTY  out  1  FIFO holds no bytes
- FULL  out  1  FIFO holds FIFO_DEPTH bytes
- OVF  out  1  sticky flag: a port write was dropped

## Operation

- Reset values: TXD=1, BUSY=0, EMPTY=1, FULL=0, OVF=0. FIFO pointers, count, bit counter and baud counter all clear to 0. State is IDLE.
- Push: WE=1 and ADDR==PORT_ADDR at a rising edge writes DIN into the FIFO.
- If the FIFO is full and no pop happens on the same edge, the byte is dropped and OVF is set to 1. OVF clears only on CLR.
- Writes to any other address are ignored.
- Pop: the transmitter takes the head byte into its shift register when it enters START.
- Push and pop on the same edge are both honoured, including when the FIFO is full; the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE → START when the FIFO is not empty; the pop happens on this edge.
  - START: TXD=0 for CLKS_PER_BIT cycles, then → DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; then → STOP (or → PARITY when configured).
  - STOP: TXD=1 for CLKS_PER_BIT cycles.
  - On the last cycle of STOP: if the FIFO is not empty, pop and go → START (back-to-back, no idle gap); otherwise → IDLE.
- BUSY=1 in every state except IDLE.
- TXD is driven from a register so it is glitch-free.
- The baud counter counts 0..CLKS_PER_BIT-1 and reloads at every bit boundary. Its width is $clog2(CLKS_PER_BIT).

## Timing

- Latency: a port write at edge N reaches the FIFO at N. If the block is IDLE, it pops at N+1, and TXD falls and BUSY rises immediately after N+1.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
- Back-to-back frames are spaced exactly one frame length apart.
- EMPTY and FULL are registered. They reflect the count after the current edge's push/pop.
- CLR mid-frame aborts the frame at once: TXD returns to 1, the FIFO is emptied and OVF is cleared. The partial frame is not resumed.
- When the CPU writes to PORT_ADDR, the RAM write itself is unaffected.

## Configuration

- UART_PARITY_EN defined:
  - The PARITY state is inserted between DATA and STOP.
  - TXD carries the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - The frame becomes 11 bits.
- UART_PARITY_EN undefined: no PARITY state and no parity logic; the frame is 8N1.

## Test plan

- Single byte (CLKS_PER_BIT=4): write 8'hA5 to 8'hFF at edge N → TXD=0 for cycles N+1..N+4. Data bits follow as 1,0,1,0,0,1,0,1, four cycles each, then stop=1. BUSY falls at N+41 and EMPTY stays 1 after the pop.
- Back-to-back: write 8'h01 then 8'h80 on consecutive cycles → two frames 40 cycles apart with no idle gap. BUSY is held high for 80 cycles.
- Overflow (FIFO_DEPTH=4): six consecutive port writes 8'h10..8'h15 while IDLE → 8'h10 goes to the transmitter and 8'h11..8'h14 fill the FIFO (FULL=1). 8'h15 is dropped and OVF=1. Exactly five frames are sent, in order.
- Address filter: write 8'h3C to 8'hFE, then perform a read of 8'hFF with WE=0 → no frame, BUSY=0, EMPTY=1.
- Reset mid-frame: assert CLR during DATA bit 3 of 8'hFF with 2 bytes queued → TXD=1, BUSY=0, EMPTY=1 and OVF=0 immediately. No further frames are sent.
- Parity (UART_PARITY_EN defined): write 8'h07 → parity bit=1 appears after bit 7. The frame is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/output_port_uart.sv
// output_port_uart: memory-bus serial output port.
// Every CPU write to PORT_ADDR is captured into a small byte FIFO and sent out
// on TXD as an 8N1 UART frame (start, 8 data bits LSB first, stop).
// Optional feature macro: UART_PARITY_EN inserts an even parity bit between
// the last data bit and the stop bit, making the frame 11 bits long.
module output_port_uart #(
   parameter logic [7:0] PORT_ADDR    = 8'hFF,
   parameter int          CLKS_PER_BIT = 10,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       WE,
   input  logic [7:0] ADDR,
   input  logic [7:0] DIN,
   output logic       TXD,
   output logic       BUSY,
   output logic       EMPTY,
   output logic       FULL,
   output logic       OVF
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bitCnt_q, bitCnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              txd_q, txd_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              ovf_q, ovf_d;
`ifdef UART_PARITY_EN
   logic              parity_q, parity_d;
`endif

   logic [7:0] fifoMem [FIFO_DEPTH];
   logic [7:0] head;
   logic       pushReq;
   logic       push;
   logic       pop;
   logic       bitEnd;

   assign head = fifoMem[rdPtr_q];

   // Next-state logic for the transmitter FSM, the shifter and the FIFO bookkeeping
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bitCnt_d = bitCnt_q;
      shift_d  = shift_q;
      txd_d    = txd_q;
      pop      = 1'b0;
`ifdef UART_PARITY_EN
      parity_d = parity_q;
`endif
      bitEnd = (baud_q == BAUD_LAST);

      if (state_q != ST_IDLE) begin
         baud_d = bitEnd ? '0 : baud_q + BAUD_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
            end
         end
         ST_START: begin
            if (bitEnd) begin
               state_d  = ST_DATA;
               bitCnt_d = 3'd0;
               txd_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bitEnd) begin
               if (bitCnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = ST_PARITY;
                  txd_d   = parity_q;
`else
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  shift_d  = {1'b0, shift_q[7:1]};
                  txd_d    = shift_q[1];
                  bitCnt_d = bitCnt_q + 3'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (bitEnd) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bitEnd) begin
               if (count_q != '0) begin
                  pop = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Taking a byte always starts a fresh frame with the start bit on the line.
      if (pop) begin
         state_d = ST_START;
         shift_d = head;
         txd_d   = 1'b0;
         baud_d  = '0;
`ifdef UART_PARITY_EN
         parity_d = ^head;
`endif
      end

      pushReq = WE && (ADDR == PORT_ADDR);
      push    = pushReq && (!full_q || pop);
      ovf_d   = ovf_q | (pushReq & full_q & ~pop);

      wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == CNT_FULL);
   end

   // FSM state register
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and FIFO control registers; reset aborts any frame in flight
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         baud_q   <= '0;
         bitCnt_q <= 3'd0;
         shift_q  <= 8'h00;
         txd_q    <= 1'b1;
         rdPtr_q  <= '0;
         wrPtr_q  <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef UART_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         baud_q   <= baud_d;
         bitCnt_q <= bitCnt_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
         rdPtr_q  <= rdPtr_d;
         wrPtr_q  <= wrPtr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
`ifdef UART_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge CLK) begin
      if (push) begin
         fifoMem[wrPtr_q] <= DIN;
      end
   end

   assign TXD   = txd_q;
   assign BUSY  = (state_q != ST_IDLE);
   assign EMPTY = empty_q;
   assign FULL  = full_q;
   assign OVF   = ovf_q;

endmodule

// File: tb/tb_output_port_uart.sv
// tb_output_port_uart: self-checking bench for output_port_uart.
// A frame-level model (byte queue plus elapsed-cycle counter) predicts every
// output on every cycle, and a UART receiver decodes TXD back into bytes.
// Build with UART_PARITY_EN defined to exercise the 11-bit frame.
module tb_output_port_uart;

   localparam logic [7:0] PORT  = 8'hFF;
   localparam int         CPB   = 4;
   localparam int         DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic       WE = 1'b0;
   logic [7:0] ADDR = 8'h00;
   logic [7:0] DIN = 8'h00;
   logic       TXD, BUSY, EMPTY, FULL, OVF;

   int nChecks = 0;
   int nFail   = 0;
   bit checkEn = 1'b0;

   output_port_uart #(
      .PORT_ADDR   (PORT),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .CLK  (CLK),
      .CLR  (CLR),
      .WE   (WE),
      .ADDR (ADDR),
      .DIN  (DIN),
      .TXD  (TXD),
      .BUSY (BUSY),
      .EMPTY(EMPTY),
      .FULL (FULL),
      .OVF  (OVF)
   );

   // Free-running system clock, 10 time units per period
   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: the FIFO is a queue, the transmitter is "busy with byte
   // mByte for mElapsed cycles so far"; the line level follows from arithmetic.
   logic [7:0] mq [$];
   logic [7:0] expSent [$];
   logic [7:0] rxLog [$];
   bit         mActive = 1'b0;
   int         mElapsed = 0;
   logic [7:0] mByte = 8'h00;
   bit         mOvf = 1'b0;
   bit         mPop, mFrameEnd, mPushReq;
   int         mSize;
   logic [7:0] mHead;

   function automatic logic modelTxd();
      int k;
      if (!mActive) return 1'b1;
      k = mElapsed / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return mByte[k-1];
`ifdef UART_PARITY_EN
      if (k == 9) return ^mByte;
`endif
      return 1'b1;
   endfunction

   // Advance the model on every clock edge; reset empties everything at once
   always @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         mq.delete();
         expSent.delete();
         mActive  = 1'b0;
         mElapsed = 0;
         mOvf     = 1'b0;
      end else begin
         mSize     = mq.size();
         mFrameEnd = mActive && (mElapsed == FRAME - 1);
         mPop      = (mSize > 0) && (!mActive || mFrameEnd);
         mPushReq  = WE && (ADDR == PORT);
         if (mPop) mHead = mq.pop_front();
         if (mPushReq) begin
            if (mSize < DEPTH || mPop) mq.push_back(DIN);
            else mOvf = 1'b1;
         end
         if (mPop) begin
            mActive  = 1'b1;
            mElapsed = 0;
            mByte    = mHead;
            expSent.push_back(mHead);
         end else if (mFrameEnd) begin
            mActive = 1'b0;
         end else if (mActive) begin
            mElapsed++;
         end
      end
   end

   // Receiver state: hunts for a start bit, then samples each bit mid-cell
   bit         rxHunt = 1'b1;
   int         rxCnt = 0;
   int         rxK;
   logic [7:0] rxShift = 8'h00;

   // Compare DUT against the model every cycle and decode the serial line
   always @(negedge CLK) begin
      if (checkEn) begin
         checkOutput("txd", TXD, modelTxd());
         checkOutput("busy", BUSY, mActive);
         checkOutput("empty", EMPTY, mq.size() == 0);
         checkOutput("full", FULL, mq.size() == DEPTH);
         checkOutput("ovf", OVF, mOvf);
      end
      if (CLR) begin
         rxHunt = 1'b1;
      end else if (rxHunt) begin
         if (TXD == 1'b0) begin
            rxHunt = 1'b0;
            rxCnt  = 0;
         end
      end else begin
         rxCnt++;
      end
      if (!CLR && !rxHunt && (rxCnt % CPB == CPB / 2)) begin
         rxK = rxCnt / CPB;
         if (rxK >= 1 && rxK <= 8) rxShift[rxK-1] = TXD;
`ifdef UART_PARITY_EN
         if (rxK == 9) checkOutput("rx parity", TXD, ^rxShift);
`endif
         if (rxK == NBITS - 1) begin
            checkOutput("rx stop", TXD, 1'b1);
            if (expSent.size() == 0) begin
               nChecks++;
               nFail++;
               $display("[TB] FAIL rx unexpected frame: actual=%0h expected=none", rxShift);
            end else begin
               checkOutput("rx byte", rxShift, expSent.pop_front());
            end
            rxLog.push_back(rxShift);
            rxHunt = 1'b1;
         end
      end
   end

   // Drive one bus cycle (called just after a falling edge) and wait for the next falling edge
   task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] din);
      WE   = we;
      ADDR = addr;
      DIN  = din;
      @(negedge CLK);
   endtask

   // Pulse the asynchronous reset well away from the rising edge
   task automatic resetDut();
      #2 CLR = 1'b1;
      @(negedge CLK);
      #2 CLR = 1'b0;
   endtask

   // Bounded wait for the port to go quiet; an expired bound shows up as a BUSY failure
   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      while ((BUSY || !EMPTY) && n < limit) begin
         @(negedge CLK);
         n++;
      end
      checkOutput("idle wait busy", BUSY, 1'b0);
   endtask

   logic [NBITS-1:0] a5Exp;
   int rxBase;
   int pct;

   // Directed scenarios with hand-computed expectations, then randomized traffic
   initial begin
`ifdef UART_PARITY_EN
      a5Exp = 11'b1_0_1010_0101_0;
`else
      a5Exp = 10'b1_1010_0101_0;
`endif
      repeat (3) @(negedge CLK);
      #2 CLR = 1'b0;
      checkEn = 1'b1;
      @(negedge CLK);
      checkOutput("reset txd", TXD, 1'b1);
      checkOutput("reset busy", BUSY, 1'b0);
      checkOutput("reset empty", EMPTY, 1'b1);
      checkOutput("reset full", FULL, 1'b0);
      checkOutput("reset ovf", OVF, 1'b0);

      // Single byte 8'hA5: literal bit pattern and frame length
      applyStimulus(1'b1, PORT, 8'hA5);
      WE = 1'b0;
      checkOutput("a5 queued empty", EMPTY, 1'b0);
      for (int i = 1; i <= FRAME + 1; i++) begin
         @(negedge CLK);
         if (i == 1) checkOutput("a5 popped empty", EMPTY, 1'b1);
         if (i <= FRAME && ((i - 1) % CPB == 1))
            checkOutput("a5 line bit", TXD, a5Exp[(i - 1) / CPB]);
         if (i == FRAME) checkOutput("a5 busy last", BUSY, 1'b1);
         if (i == FRAME + 1) checkOutput("a5 busy end", BUSY, 1'b0);
      end
      waitIdle(100);

      // Back-to-back frames with no idle gap
      rxBase = rxLog.size();
      applyStimulus(1'b1, PORT, 8'h01);
      applyStimulus(1'b1, PORT, 8'h80);
      WE = 1'b0;
      for (int i = 2; i <= 2 * FRAME + 1; i++) begin
         @(negedge CLK);
         if (i == FRAME + 1) begin
            checkOutput("b2b busy held", BUSY, 1'b1);
            checkOutput("b2b second start", TXD, 1'b0);
         end
         if (i == 2 * FRAME) checkOutput("b2b busy last", BUSY, 1'b1);
         if (i == 2 * FRAME + 1) checkOutput("b2b busy end", BUSY, 1'b0);
      end
      checkOutput("b2b frame count", rxLog.size() - rxBase, 2);
      checkOutput("b2b byte0", rxLog[rxBase], 8'h01);
      checkOutput("b2b byte1", rxLog[rxBase + 1], 8'h80);

      // Overflow: six writes, one in flight, four buffered, one dropped
      rxBase = rxLog.size();
      for (int b = 0; b < 6; b++) applyStimulus(1'b1, PORT, 8'(16 + b));
      WE = 1'b0;
      checkOutput("ovf full", FULL, 1'b1);
      checkOutput("ovf flag", OVF, 1'b1);
      waitIdle(6 * FRAME + 50);
      checkOutput("ovf frame count", rxLog.size() - rxBase, 5);
      for (int j = 0; j < 5 && rxBase + j < rxLog.size(); j++)
         checkOutput("ovf order", rxLog[rxBase + j], 8'(16 + j));
      checkOutput("ovf sticky", OVF, 1'b1);

      // Address filter: other addresses and reads are ignored
      rxBase = rxLog.size();
      applyStimulus(1'b1, 8'hFE, 8'h3C);
      applyStimulus(1'b0, PORT, 8'h3C);
      repeat (FRAME) @(negedge CLK);
      checkOutput("filter busy", BUSY, 1'b0);
      checkOutput("filter empty", EMPTY, 1'b1);
      checkOutput("filter frames", rxLog.size() - rxBase, 0);

      // Reset during data bit 3 with two bytes queued
      rxBase = rxLog.size();
      applyStimulus(1'b1, PORT, 8'hFF);
      applyStimulus(1'b1, PORT, 8'h11);
      applyStimulus(1'b1, PORT, 8'h22);
      WE = 1'b0;
      repeat (15) @(negedge CLK);
      #2 CLR = 1'b1;
      #1;
      checkOutput("clr txd", TXD, 1'b1);
      checkOutput("clr busy", BUSY, 1'b0);
      checkOutput("clr empty", EMPTY, 1'b1);
      checkOutput("clr ovf", OVF, 1'b0);
      @(negedge CLK);
      #2 CLR = 1'b0;
      repeat (3 * FRAME) @(negedge CLK);
      checkOutput("clr no frames", rxLog.size() - rxBase, 0);
      checkOutput("clr stays idle", BUSY, 1'b0);

`ifdef UART_PARITY_EN
      // Parity bit for 8'h07 is 1 and the frame lasts 11 bit times
      applyStimulus(1'b1, PORT, 8'h07);
      WE = 1'b0;
      for (int i = 1; i <= FRAME + 1; i++) begin
         @(negedge CLK);
         if (i == 9 * CPB + 2) checkOutput("parity bit", TXD, 1'b1);
         if (i == FRAME) checkOutput("parity busy last", BUSY, 1'b1);
         if (i == FRAME + 1) checkOutput("parity busy end", BUSY, 1'b0);
      end
`endif

      // Randomized traffic in phases of differing write density, with a reset mid-way
      for (int ph = 0; ph < 4; ph++) begin
         pct = (ph == 0) ? 4 : (ph == 1) ? 40 : (ph == 2) ? 3 : 60;
         if (ph == 2) resetDut();
         for (int c = 0; c < 500; c++) begin
            applyStimulus($urandom_range(0, 99) < pct,
                          ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : PORT,
                          8'($urandom));
         end
         WE = 1'b0;
      end
      waitIdle((DEPTH + 2) * FRAME + 100);
      checkOutput("all frames received", expSent.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
